reg_file_wb_arbiter: RTL and testbench

//   Shares the single register-file write port among NUM_REQ writeback requesters, e.g. ALU and load unit.

---
 rtl/reg_file_wb_arbiter.sv | 91 +++++++++
 tb/tb_reg_file_wb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_wb_arbiter.sv
// rtl/reg_file_wb_arbiter.sv - round-robin writeback arbiter for the shared register-file write port
module reg_file_wb_arbiter #(
    parameter int  NUM_REQ    = 2,
    parameter int  DATA_WIDTH = 32,
    parameter int  ADDR_WIDTH = 5,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_reg,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_reg,
    output logic [DATA_WIDTH-1:0]         wr_data,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic [15:0]                   stall_cnt
);

    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_reg_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [ID_WIDTH-1:0]   grant_id_q;
    logic [15:0]           stall_q;

    logic                  accept;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [ID_WIDTH:0]     n_valid;
    logic [ID_WIDTH:0]     cand_sum;
    logic                  contention;
    logic [ADDR_WIDTH-1:0] sel_reg;
    logic [DATA_WIDTH-1:0] sel_data;

    // Circular scan from rr_ptr; sum is one bit wider so non-power-of-two NUM_REQ wraps correctly.
    always_comb begin
        accept    = 1'b0;
        grant_idx = '0;
        n_valid   = '0;
        cand_sum  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_sum = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
            if (cand_sum >= (ID_WIDTH+1)'(NUM_REQ))
                cand_sum = cand_sum - (ID_WIDTH+1)'(NUM_REQ);
            if (!accept && req_valid[cand_sum[ID_WIDTH-1:0]]) begin
                accept    = 1'b1;
                grant_idx = cand_sum[ID_WIDTH-1:0];
            end
            n_valid = n_valid + {{ID_WIDTH{1'b0}}, req_valid[k]};
        end
        if (rst)
            accept = 1'b0;
        contention = (n_valid >= (ID_WIDTH+1)'(2));
        rr_ptr_d   = (grant_idx == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_idx + ID_WIDTH'(1);
        sel_reg    = req_reg[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data   = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 0; k < NUM_REQ; k++)
            req_ready[k] = accept && (grant_idx == ID_WIDTH'(k));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_reg_q   <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
            stall_q    <= '0;
        end else begin
            if (accept) begin
                rr_ptr_q   <= rr_ptr_d;
                wr_en_q    <= (sel_reg != '0);
                wr_reg_q   <= sel_reg;
                wr_data_q  <= sel_data;
                grant_id_q <= grant_idx;
            end else begin
                wr_en_q <= 1'b0;
            end
            if (contention && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_reg    = wr_reg_q;
    assign wr_data   = wr_data_q;
    assign grant_id  = grant_id_q;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_reg_file_wb_arbiter.sv
// tb/tb_reg_file_wb_arbiter.sv - randomized self-checking bench for reg_file_wb_arbiter
module tb_reg_file_wb_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_reg;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            wr_en;
    logic [AW-1:0]   wr_reg;
    logic [DW-1:0]   wr_data;
    logic            grant_id;
    logic [15:0]     stall_cnt;

    int total = 0;
    int bad   = 0;

    // model state
    int          m_ptr;
    logic        m_wr_en;
    logic [AW-1:0] m_wr_reg;
    logic [DW-1:0] m_wr_data;
    int          m_gid;
    int          m_stall;
    logic [DW-1:0] m_rf   [32];
    logic [DW-1:0] dut_rf [32];
    int          last_g;

    reg_file_wb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_reg(req_reg), .req_data(req_data),
        .req_ready(req_ready), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .grant_id(grant_id), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic int model_grant();
        if (rst) return -1;
        for (int k = 0; k < N; k++) begin
            int p;
            p = (m_ptr + k) % N;
            if (req_valid[p]) return p;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        logic [N-1:0] r;
        g = model_grant();
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_reg[i*AW +: AW]  = r;
        req_data[i*DW +: DW] = d;
    endtask

    // Advance one clock and update the reference model; comparisons live in the tests.
    task automatic tick();
        int g;
        int nv;
        logic [AW-1:0] r;
        g  = model_grant();
        nv = 0;
        for (int k = 0; k < N; k++) nv += int'(req_valid[k]);
        r = (g >= 0) ? req_reg[g*AW +: AW] : '0;
        @(posedge clk);
        last_g = g;
        if (rst) begin
            m_ptr = 0; m_wr_en = 0; m_wr_reg = '0; m_wr_data = '0; m_gid = 0; m_stall = 0;
        end else begin
            if (g >= 0) begin
                m_wr_en   = (r != 0);
                m_wr_reg  = r;
                m_wr_data = req_data[g*DW +: DW];
                m_gid     = g;
                m_ptr     = (g + 1) % N;
            end else begin
                m_wr_en = 0;
            end
            if (nv >= 2 && m_stall < 65535) m_stall++;
        end
        if (m_wr_en) m_rf[m_wr_reg] = m_wr_data;
        #1;
        if (wr_en === 1'b1) dut_rf[wr_reg] = wr_data;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        req_reg = '1;
        req_data = '1;
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        tick();
        rst = 1'b0;
        req_valid = '0;
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
        total++; if (wr_reg !== 5'd0 || wr_data !== 32'd0) begin bad++; $display("FAIL reset_wr got=%0d/%h exp=0/0", wr_reg, wr_data); end
        total++; if (grant_id !== 1'b0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%b/%0d exp=0/0", grant_id, stall_cnt); end
    endtask

    task automatic test_single();
        set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL single_ready got=%b exp=10", req_ready); end
        tick();
        req_valid = '0;
        total++; if (wr_en !== 1'b1 || wr_reg !== 5'd7 || wr_data !== 32'hDEADBEEF || grant_id !== 1'b1) begin
            bad++; $display("FAIL single_write got=%b/%0d/%h/%b exp=1/7/deadbeef/1", wr_en, wr_reg, wr_data, grant_id); end
        tick();
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL single_idle got=%b exp=0", wr_en); end
    endtask

    task automatic test_contention();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            logic [N-1:0] er;
            set_req(0, 1'b1, 5'd10, 32'hA000_0000 + c);
            set_req(1, 1'b1, 5'd11, 32'hB000_0000 + c);
            er = (c % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            total++; if (req_ready !== er) begin bad++; $display("FAIL contention_ready c=%0d got=%b exp=%b", c, req_ready, er); end
            tick();
            total++; if (wr_en !== 1'b1 || grant_id !== 1'(c % 2) || wr_data !== ((c % 2 == 0) ? 32'hA000_0000 + c : 32'hB000_0000 + c)) begin
                bad++; $display("FAIL contention_write c=%0d got=%b/%b/%h", c, wr_en, grant_id, wr_data); end
        end
        req_valid = '0;
        total++; if (stall_cnt !== 16'd4) begin bad++; $display("FAIL contention_stall got=%0d exp=4", stall_cnt); end
        tick();
    endtask

    task automatic test_x0();
        set_req(0, 1'b1, 5'd0, 32'h1234);
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL x0_ready got=%b exp=01", req_ready); end
        tick();
        total++; if (wr_en !== 1'b0 || grant_id !== 1'b0) begin bad++; $display("FAIL x0_write got=%b/%b exp=0/0", wr_en, grant_id); end
        set_req(0, 1'b1, 5'd3, 32'h3);
        set_req(1, 1'b1, 5'd4, 32'h4);
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL x0_tie got=%b exp=10", req_ready); end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_same_dest();
        set_req(0, 1'b1, 5'd9, 32'h9);
        tick();
        set_req(0, 1'b1, 5'd5, 32'hAAAA_AAAA);
        set_req(1, 1'b1, 5'd5, 32'hBBBB_BBBB);
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL same_first got=%b exp=10", req_ready); end
        tick();
        req_valid[1] = 1'b0;
        total++; if (wr_data !== 32'hBBBB_BBBB || wr_en !== 1'b1) begin bad++; $display("FAIL same_b got=%h exp=bbbbbbbb", wr_data); end
        tick();
        req_valid = '0;
        total++; if (wr_data !== 32'hAAAA_AAAA || wr_en !== 1'b1) begin bad++; $display("FAIL same_a got=%h exp=aaaaaaaa", wr_data); end
        tick();
        total++; if (dut_rf[5] !== 32'hAAAA_AAAA) begin bad++; $display("FAIL same_final got=%h exp=aaaaaaaa", dut_rf[5]); end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] || last_g == i)
                    set_req(i, 1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom);
            rst = ($urandom_range(0, 49) == 0);
            #1;
            total++; if (req_ready !== exp_ready()) begin bad++; errs++;
                if (errs < 10) $display("FAIL rand_ready c=%0d got=%b exp=%b", c, req_ready, exp_ready()); end
            tick();
            rst = 1'b0;
            total++; if (wr_en !== m_wr_en || wr_reg !== m_wr_reg || wr_data !== m_wr_data ||
                         grant_id !== 1'(m_gid) || stall_cnt !== 16'(m_stall)) begin bad++; errs++;
                if (errs < 10) $display("FAIL rand_out c=%0d got=%b/%0d/%h/%b/%0d exp=%b/%0d/%h/%0d/%0d", c,
                    wr_en, wr_reg, wr_data, grant_id, stall_cnt, m_wr_en, m_wr_reg, m_wr_data, m_gid, m_stall); end
        end
        req_valid = '0;
        tick();
        for (int r = 1; r < 8; r++) begin
            total++; if (dut_rf[r] !== m_rf[r]) begin bad++; $display("FAIL rand_rf r=%0d got=%h exp=%h", r, dut_rf[r], m_rf[r]); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_req(0, 1'b1, 5'd1, 32'h11);
        set_req(1, 1'b1, 5'd2, 32'h22);
        for (int c = 0; c < 65540; c++) tick();
        total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h exp=ffff", stall_cnt); end
        for (int c = 0; c < 5; c++) tick();
        total++; if (stall_cnt !== 16'hFFFF || wr_en !== 1'b1) begin bad++; $display("FAIL sat_hold got=%h/%b exp=ffff/1", stall_cnt, wr_en); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (wr_en !== 1'b0 || stall_cnt !== 16'd0 || grant_id !== 1'b0) begin
            bad++; $display("FAIL sat_reset got=%b/%h/%b exp=0/0/0", wr_en, stall_cnt, grant_id); end
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL sat_after got=%b exp=01", req_ready); end
        req_valid = '0;
        tick();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin m_rf[r] = '0; dut_rf[r] = '0; end
        m_ptr = 0; m_wr_en = 0; m_wr_reg = '0; m_wr_data = '0; m_gid = 0; m_stall = 0; last_g = -1;
        rst = 1'b1; req_valid = '0; req_reg = '0; req_data = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_x0();
        test_same_dest();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
